// File: rtl/ifetch_unit.sv
// Instruction fetch stage: keeps the fetch PC, issues one-word reads and pushes {pc, instr} into the queue.
// Optional IFETCH_JAL_FOLLOW_EN makes the PC follow JAL targets as words are pushed.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] q_size,
  output logic        q_push,
  output logic [63:0] q_push_data,
  output logic        q_clear
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  localparam logic [31:0] QDEPTH_W = 32'(QDEPTH);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] next_pc;

  // Fetch addresses are word aligned, so the low bits of a redirect target carry no information.
  logic unused_flush_lsbs;
  assign unused_flush_lsbs = ^flush_pc[1:0];

  assign q_clear     = flush;
  assign mem_req     = (state == REQ) || (state == DISCARD);
  assign mem_addr    = mem_req ? req_addr : 32'h0;
  assign q_push      = (state == REQ) && mem_ack && !flush;
  assign q_push_data = q_push ? {req_addr, mem_rdata} : 64'h0;

`ifdef IFETCH_JAL_FOLLOW_EN
  // J-immediate with bit 1 dropped: targets are word aligned, so it can never be set.
  logic [31:0] jal_imm;
  assign jal_imm = {{12{mem_rdata[31]}}, mem_rdata[19:12], mem_rdata[20],
                    mem_rdata[30:22], 2'b00};
  assign next_pc = (mem_rdata[6:0] == 7'b1101111) ? req_addr + jal_imm
                                                  : req_addr + 32'd4;
`else
  assign next_pc = req_addr + 32'd4;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= {RESET_PC[31:2], 2'b00};
      req_addr <= 32'h0;
    end else begin
      if (flush)
        pc <= {flush_pc[31:2], 2'b00};
      else if (q_push)
        pc <= next_pc;

      case (state)
        IDLE: begin
          if (!flush && (q_size < QDEPTH_W)) begin
            state    <= REQ;
            req_addr <= pc;
          end
        end
        // The controller cannot cancel a read, so a flush without the ack must wait it out.
        REQ: begin
          if (mem_ack)
            state <= IDLE;
          else if (flush)
            state <= DISCARD;
        end
        DISCARD: begin
          if (mem_ack)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a latency-2 memory responder, expected pushes queued
// by the stimulus and popped by a push monitor.
module tb_ifetch_unit;

  localparam int LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] flush_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] q_size;
  logic        q_push;
  logic [63:0] q_push_data;
  logic        q_clear;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [63:0] sb[$];

  ifetch_unit #(.RESET_PC(32'h0), .QDEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .q_size(q_size), .q_push(q_push), .q_push_data(q_push_data), .q_clear(q_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0000_0008: return 32'hDEAD_BEEF;
      32'h0000_0020: return 32'h0100_006F;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int n = 0;
    while (!mem_req && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_req"}, {63'h0, mem_req}, 64'h1);
    check({tag, "_addr"}, {32'h0, mem_addr}, {32'h0, exp_addr});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (mem_req && n < 60) begin
      tick();
      n++;
    end
    if (mem_req) check({tag, "_idle_timeout"}, {63'h0, mem_req}, 64'h0);
  endtask

  task automatic expect_push(input logic [31:0] a);
    sb.push_back({a, word_at(a)});
  endtask

  // Single-cycle flush; q_clear must follow flush combinationally and no push may escape.
  task automatic pulse_flush(input string tag, input logic [31:0] target);
    flush    = 1'b1;
    flush_pc = target;
    @(negedge clk);
    check({tag, "_clear"}, {63'h0, q_clear}, 64'h1);
    check({tag, "_nopush"}, {63'h0, q_push}, 64'h0);
    check({tag, "_pdata0"}, q_push_data, 64'h0);
    tick();
    flush = 1'b0;
  endtask

  // Memory responder: ack LAT cycles after mem_req rises, one-cycle pulse.
  initial begin
    int cnt = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
      end else if (mem_ack) begin
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
      end else if (mem_req) begin
        cnt++;
        if (cnt == LAT) begin
          mem_ack = 1'b1;
          mem_rdata = word_at(mem_addr);
        end
      end
    end
  end

  // Push monitor: every push must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (q_push) begin
        if (sb.size() == 0) check("push_unexpected", {63'h0, q_push}, 64'h0);
        else check("push_data", q_push_data, sb.pop_front());
      end
    end
  end

  initial begin
    int rise0, rise1, rise2;
    rst_n    = 1'b0;
    flush    = 1'b0;
    flush_pc = 32'h0;
    q_size   = 32'd0;
    #2;
    check("rst_mem_req", {63'h0, mem_req}, 64'h0);
    check("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
    check("rst_q_push", {63'h0, q_push}, 64'h0);
    check("rst_q_push_data", q_push_data, 64'h0);
    check("rst_q_clear", {63'h0, q_clear}, 64'h0);
    tick();
    tick();

    // Sequential fetch from reset PC.
    expect_push(32'h0);
    expect_push(32'h4);
    expect_push(32'h8);
    rst_n = 1'b1;
    wait_req("seq0", 32'h0);
    rise0 = cyc;
    wait_idle("seq0");
    wait_req("seq1", 32'h4);
    rise1 = cyc;
    wait_idle("seq1");
    wait_req("seq2", 32'h8);
    rise2 = cyc;
    q_size = 32'd16;
    check("cadence01", 64'(rise1 - rise0), 64'(LAT + 1));
    check("cadence12", 64'(rise2 - rise1), 64'(LAT + 1));
    wait_idle("seq2");

    // Full queue holds fetch off; one free slot resumes it next cycle.
    for (int i = 0; i < 8; i++) begin
      tick();
      check("full_no_req", {63'h0, mem_req}, 64'h0);
    end
    expect_push(32'hC);
    q_size = 32'd15;
    tick();
    check("resume_req", {63'h0, mem_req}, 64'h1);
    check("resume_addr", {32'h0, mem_addr}, 64'hC);
    q_size = 32'd16;
    wait_idle("resume");

    // Flush while a read at 0x8 is outstanding: data dropped, redirect to 0x100.
    pulse_flush("fl_idle", 32'h8);
    q_size = 32'd0;
    wait_req("fl_req", 32'h8);
    pulse_flush("fl_req", 32'h100);
    check("discard_req", {63'h0, mem_req}, 64'h1);
    check("discard_addr", {32'h0, mem_addr}, 64'h8);
    expect_push(32'h100);
    wait_idle("discard");
    wait_req("fl_new", 32'h100);
    q_size = 32'd16;
    wait_idle("fl_new");

    // Flush in the same cycle as mem_ack.
    q_size = 32'd0;
    wait_req("co", 32'h104);
    tick();
    pulse_flush("co_ack", 32'h200);
    expect_push(32'h200);
    wait_req("co_new", 32'h200);
    q_size = 32'd16;
    wait_idle("co_new");

    // PC wrap; flush target low bits ignored.
    pulse_flush("wrap", 32'hFFFF_FFFF);
    expect_push(32'hFFFF_FFFC);
    expect_push(32'h0);
    q_size = 32'd0;
    wait_req("wrap_top", 32'hFFFF_FFFC);
    wait_idle("wrap_top");
    wait_req("wrap_zero", 32'h0);
    q_size = 32'd16;
    wait_idle("wrap_zero");

    // JAL word at 0x20 (jal x0,+16).
    pulse_flush("jal", 32'h20);
    expect_push(32'h20);
`ifdef IFETCH_JAL_FOLLOW_EN
    expect_push(32'h30);
`else
    expect_push(32'h24);
`endif
    q_size = 32'd0;
    wait_req("jal_at", 32'h20);
    wait_idle("jal_at");
`ifdef IFETCH_JAL_FOLLOW_EN
    wait_req("jal_next", 32'h30);
`else
    wait_req("jal_next", 32'h24);
`endif
    q_size = 32'd16;
    wait_idle("jal_next");

    // Reset in the middle of a read: the pending ack never arrives, fetch restarts at RESET_PC.
    pulse_flush("mid", 32'h40);
    q_size = 32'd0;
    wait_req("mid", 32'h40);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", {63'h0, mem_req}, 64'h0);
    tick();
    tick();
    expect_push(32'h0);
    rst_n = 1'b1;
    wait_req("post_rst", 32'h0);
    q_size = 32'd16;
    wait_idle("post_rst");
    tick();
    tick();
    check("sb_empty", 64'(sb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
